// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames 11-bit serial words and folds E0/F0 prefixes into {ext, byte} key codes.
// make/brake/rx_err are single-cycle pulses, registered one clk after the stop-bit edge; no backpressure.
module ps2_key_decoder #(
    parameter int KEYCODE_WIDTH  = 9,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [KEYCODE_WIDTH-1:0] keyCode,
    output logic                     make,
    output logic                     brake,
    output logic                     rx_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic                     clk_meta_q, clk_sync_q, clk_prev_q;
    logic                     dat_meta_q, dat_sync_q;
    logic [1:0]               state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic                     parity_q, parity_d;
    logic [CNT_W-1:0]         idle_cnt_q, idle_cnt_d;
    logic                     ext_q, ext_d;
    logic                     brk_q, brk_d;
    logic [KEYCODE_WIDTH-1:0] key_q, key_d;
    logic                     make_q, make_d;
    logic                     brake_q, brake_d;
    logic                     err_q, err_d;
    logic                     fall;
    logic                     frame_ok;

    assign fall     = clk_prev_q & ~clk_sync_q;
    // Odd parity over the eight data bits plus the parity bit, and a high stop bit
    assign frame_ok = (^{shift_q, parity_q}) & dat_sync_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        key_d      = key_q;
        make_d     = 1'b0;
        brake_d    = 1'b0;
        err_d      = 1'b0;
        idle_cnt_d = idle_cnt_q;

        if (fall) begin
            idle_cnt_d = '0;
        end else if (state_q != S_IDLE && idle_cnt_q != TIMEOUT_VAL) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end

        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = dat_sync_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (frame_ok) begin
                        case (shift_q)
                            8'hE0:   ext_d = 1'b1;
                            8'hF0:   brk_d = 1'b1;
                            8'hE1:   ;
                            default: begin
                                key_d   = KEYCODE_WIDTH'({ext_q, shift_q});
                                make_d  = ~brk_q;
                                brake_d = brk_q;
                                ext_d   = 1'b0;
                                brk_d   = 1'b0;
                            end
                        endcase
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && idle_cnt_q == TIMEOUT_VAL) begin
            // Keyboard stalled mid-frame: drop it and any pending prefix
            state_d = S_IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            idle_cnt_q <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_q      <= '0;
            make_q     <= 1'b0;
            brake_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            idle_cnt_q <= idle_cnt_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            key_q      <= key_d;
            make_q     <= make_d;
            brake_q    <= brake_d;
            err_q      <= err_d;
        end
    end

    assign keyCode = key_q;
    assign make    = make_q;
    assign brake   = brake_q;
    assign rx_err  = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks codes, pulse counts and timing.
module tb_ps2_key_decoder;

    localparam int HALF = 8;
    localparam int TMO  = 400;

    logic       clk;
    logic       resetN;
    logic       ps2_clk;
    logic       ps2_data;
    logic [8:0] keyCode;
    logic       make;
    logic       brake;
    logic       rx_err;

    int tests = 0;
    int fails = 0;
    int make_cnt = 0, brake_cnt = 0, err_cnt = 0, both_cnt = 0;
    int exp_make = 0, exp_brake = 0, exp_err = 0;

    ps2_key_decoder #(.KEYCODE_WIDTH(9), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keyCode  (keyCode),
        .make     (make),
        .brake    (brake),
        .rx_err   (rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counts sampled mid-cycle; a one-cycle pulse contributes exactly 1
    always @(negedge clk) begin
        if (make)           make_cnt  <= make_cnt + 1;
        if (brake)          brake_cnt <= brake_cnt + 1;
        if (rx_err)         err_cnt   <= err_cnt + 1;
        if (make && brake)  both_cnt  <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0, 1'b1), 11);
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [8:0] key);
        chk({tag, "_key"},   {23'd0, keyCode}, {23'd0, key});
        chk({tag, "_make"},  make_cnt,  exp_make);
        chk({tag, "_brake"}, brake_cnt, exp_brake);
        chk({tag, "_err"},   err_cnt,   exp_err);
    endtask

    initial begin
        resetN   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_key",   {23'd0, keyCode}, 32'd0);
        chk("rst_make",  {31'd0, make},    32'd0);
        chk("rst_brake", {31'd0, brake},   32'd0);
        chk("rst_err",   {31'd0, rx_err},  32'd0);
        resetN = 1'b1;
        repeat (5) @(negedge clk);

        // 0x75 with a cycle-exact look at the make pulse after the stop edge
        send_bits(frame(8'h75, 1'b0, 1'b1), 10);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_early", {31'd0, make}, 32'd0);
        @(posedge clk); #1;
        chk("lat_make",  {31'd0, make},  32'd1);
        chk("lat_brake", {31'd0, brake}, 32'd0);
        chk("lat_key",   {23'd0, keyCode}, 32'h075);
        @(posedge clk); #1;
        chk("lat_width", {31'd0, make}, 32'd0);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        exp_make++;
        chk_all("k75", 9'h075);

        send_byte(8'hE0);
        chk_all("e0_only", 9'h075);
        send_byte(8'h74);
        exp_make++;
        chk_all("e0_74", 9'h174);

        send_byte(8'hF0);
        send_byte(8'h6B);
        exp_brake++;
        chk_all("f0_6b", 9'h06B);

        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        exp_brake++;
        chk_all("e0f0_74", 9'h174);

        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
        exp_brake++;
        chk_all("f0e0_75", 9'h175);

        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'hE1); send_byte(8'h16);
        exp_make++;
        chk_all("e0e0e1_16", 9'h116);

        send_bits(frame(8'h73, 1'b1, 1'b1), 11);
        repeat (10) @(negedge clk);
        exp_err++;
        chk_all("bad_par", 9'h116);
        send_byte(8'h73);
        exp_make++;
        chk_all("k73", 9'h073);

        // A rejected frame must also drop a pending break prefix
        send_byte(8'hF0);
        send_bits(frame(8'h29, 1'b0, 1'b0), 11);
        repeat (10) @(negedge clk);
        exp_err++;
        chk_all("bad_stop", 9'h073);
        send_byte(8'h1C);
        exp_make++;
        chk_all("k1c", 9'h01C);

        send_byte(8'hE0);
        send_bits(frame(8'h55, 1'b0, 1'b1), 4);
        repeat (TMO + 50) @(negedge clk);
        exp_err++;
        chk_all("timeout", 9'h01C);
        send_byte(8'h74);
        exp_make++;
        chk_all("k74", 9'h074);

        send_byte(8'hE0);
        send_bits(frame(8'h12, 1'b0, 1'b1), 3);
        @(negedge clk);
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_key", {23'd0, keyCode}, 32'd0);
        resetN = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h75);
        exp_make++;
        chk_all("post_rst", 9'h075);

        chk("never_both", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter KEYCODE_WIDTH, default 9, meaning keyCode output width (bit 8 = extended flag).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning clk cycles without a ps2 falling edge before a partial frame is discarded.
REQ-003 The block SHALL have port clk  input  1  system clock; the block uses this single clock.
REQ-004 The block SHALL have port resetN  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 The block SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 The block SHALL have port keyCode  output  KEYCODE_WIDTH  last decoded scan code, {extended, byte}.
REQ-008 The block SHALL have port make  output  1  one-cycle pulse: key press decoded.
REQ-009 The block SHALL have port brake  output  1  one-cycle pulse: key release decoded.
REQ-010 The block SHALL have port rx_err  output  1  one-cycle pulse: frame dropped (parity, stop or timeout).

Function
REQ-011 The block SHALL synchronize ps2_clk and ps2_data through two flip-flops each before any use.
REQ-012 The block SHALL detect a ps2 falling edge as synchronized ps2_clk 1 in the previous cycle and 0 in the current cycle, and SHALL sample synchronized ps2_data only in that cycle.
REQ-013 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-014 In IDLE, an edge with data 0 SHALL go to DATA; an edge with data 1 SHALL be ignored, staying in IDLE.
REQ-015 DATA SHALL shift in 8 bits LSB first with a 3-bit counter, then go to PARITY.
REQ-016 PARITY SHALL store the sampled bit and go to STOP.
REQ-017 STOP SHALL accept the byte only if data bits plus parity have odd parity and the stop bit is 1, and SHALL return to IDLE in every case.
REQ-018 A rejected frame SHALL pulse rx_err for one cycle, clear both prefix flags and leave keyCode unchanged.
REQ-019 An idle counter SHALL clear on every ps2 edge and count while the FSM is outside IDLE.
REQ-020 At TIMEOUT_CYCLES, the FSM SHALL return to IDLE, pulse rx_err and clear the prefix flags.
REQ-021 The counter SHALL saturate; it SHALL NOT wrap.
REQ-022 Byte interpretation of an accepted byte 0xE0 SHALL set the ext flag and produce no output pulse.
REQ-023 Byte interpretation of an accepted byte 0xF0 SHALL set the brk flag and produce no output pulse.
REQ-024 Byte interpretation of an accepted byte 0xE1 SHALL be discarded, with flags unchanged.
REQ-025 On any other accepted byte B, the block SHALL set keyCode = {ext, B} and pulse brake if brk is set, else make, in the same cycle as the keyCode update.
REQ-026 The make/brake pulse SHALL occur one clk cycle after the cycle in which the stop-bit edge is detected.
REQ-027 The make/brake pulse SHALL clear ext and brk.
REQ-028 make and brake SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per decoded code.
REQ-029 keyCode SHALL hold its value between codes.
REQ-030 Prefix order E0 then F0 SHALL yield an extended release.
REQ-031 Prefix order F0 then E0 SHALL yield an extended release.
REQ-032 Repeated identical prefixes SHALL be idempotent.
REQ-033 The block SHALL be receive-only and SHALL never drive ps2_clk or ps2_data.

Reset
REQ-034 When resetN is low, the block SHALL asynchronously force frame FSM = IDLE, shift register = 0, counters = 0, ext = brk = 0, keyCode = 0, make = brake = rx_err = 0 and synchronizer flops = 1.
REQ-035 A reset asserted mid-frame SHALL discard the partial frame; the next valid start bit after release SHALL be decoded normally.

Verification
REQ-036 A frame with byte 0x75 and valid parity SHALL produce keyCode = 0x075 and a make pulse of exactly 1 cycle, with brake = 0.
REQ-037 Bytes 0xE0 then 0x74 SHALL produce keyCode = 0x174 and make; no pulse SHALL occur after the 0xE0 byte.
REQ-038 Bytes 0xF0 then 0x6B SHALL produce keyCode = 0x06B and brake; bytes E0, F0, 74 SHALL produce keyCode = 0x174 and brake.
REQ-039 Byte 0x73 with a flipped parity bit SHALL produce an rx_err pulse, no make, and keyCode unchanged; a following valid 0x73 SHALL produce make with keyCode = 0x073.
REQ-040 Four bits of a frame followed by TIMEOUT_CYCLES of idle clock SHALL produce an rx_err pulse; a following valid 0x74 SHALL produce make with keyCode = 0x074.
REQ-041 A reset pulse after 0xE0 and 3 bits of the next frame, then a valid 0x75, SHALL produce keyCode = 0x075 (ext cleared) and make.
